// File: rtl/fxp_divider_param.sv
// rtl/fxp_divider_param.sv - parametrised unsigned fixed-point restoring divider with error checks
module fxp_divider_param #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dvz,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ITER  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   dvd_r;
    logic [WIDTH-1:0]   dvs_r;
    logic [WIDTH-1:0]   nbits;
    logic [WIDTH:0]     prem;
    logic [CNT_W-1:0]   cnt;
    logic               err_dvz;

    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic               borrow;
    logic               is_zero;
    logic               is_ovf;

    // The upper FRAC bits of N seed the partial remainder; the remaining WIDTH
    // bits of N (dividend low bits followed by FRAC zeros) are fed in one per cycle.
    // Overflow means those seed bits already reach the divisor, i.e. quotient >= 2^WIDTH.
    always_comb begin
        shifted = {prem[WIDTH-1:0], nbits[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_r};
        borrow  = diff[WIDTH+1];
        is_zero = (dvs_r == '0);
        is_ovf  = ((dvd_r >> (WIDTH - FRAC)) >= dvs_r);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = (is_zero || is_ovf) ? ERR : ITER;
            ITER:    if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state and error cause
    always_comb begin
        busy  = (state != IDLE);
        valid = (state == DONE) || (state == ERR);
        dvz   = (state == ERR) && err_dvz;
        ovf   = (state == ERR) && !err_dvz;
    end

    // Operand capture, check-cycle setup and one restoring step per ITER cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_r     <= '0;
            dvs_r     <= '0;
            nbits     <= '0;
            prem      <= '0;
            cnt       <= '0;
            err_dvz   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_r     <= dividend;
                        dvs_r     <= divisor;
                        quotient  <= '0;
                        remainder <= '0;
                    end
                end
                CHECK: begin
                    prem    <= {1'b0, dvd_r >> (WIDTH - FRAC)};
                    nbits   <= dvd_r << FRAC;
                    cnt     <= CNT_W'(WIDTH - 1);
                    err_dvz <= is_zero;
                    if (is_zero || is_ovf) begin
                        quotient <= '1;
                    end
                end
                ITER: begin
                    nbits    <= nbits << 1;
                    prem     <= borrow ? shifted : diff[WIDTH:0];
                    quotient <= {quotient[WIDTH-2:0], ~borrow};
                    cnt      <= cnt - 1'b1;
                    if (cnt == '0) begin
                        remainder <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
